// File: rtl/obstacle_field.sv
// obstacle_field: multi-slot cactus renderer for the runner game.
// Obstacles scroll right-to-left by `speed` pixels per frame tick. New cacti
// spawn after an LFSR-randomised frame gap. One registered obstacle pixel is
// produced per pixel clock, and a sticky flag records any overlap with the dino.
module obstacle_field #(
  parameter int                       N_OBS    = 4,
  parameter int                       SCREEN_W = 640,
  parameter int                       SPR_W    = 60,
  parameter int                       SPR_H    = 58,
  parameter int                       Y_TOP    = 344,
  parameter int                       POS_W    = 11,
  parameter int                       MIN_GAP  = 40,
  parameter logic [7:0]               GAP_MASK = 8'h3F,
  parameter logic [SPR_W*SPR_H-1:0]   SPRITE   = '0
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       START,
  input  logic       game_status,
  input  logic       fresh,
  input  logic [3:0] speed,
  input  logic [8:0] row_addr,
  input  logic [9:0] col_addr,
  input  logic       dino_px,
  output logic       px,
  output logic       collide,
  output logic [3:0] active_cnt
);

  // Pixel-index arithmetic is done at POS_W+7 bits so that neither the
  // column offset nor the row*width product can overflow.
  localparam int IDX_W  = POS_W + 7;
  localparam int SPR_N  = SPR_W * SPR_H;
  localparam int SPR_IW = (SPR_N > 1) ? $clog2(SPR_N) : 1;
  localparam int GAP_W  = $clog2(MIN_GAP + 256) + 1;

  localparam logic [15:0]      LFSR_SEED  = 16'hACE1;
  localparam logic [POS_W:0]   RETIRE_AT  = (POS_W+1)'(SCREEN_W + SPR_W);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP);
  localparam logic [IDX_W-1:0] ROW_LO     = IDX_W'(Y_TOP);
  localparam logic [IDX_W-1:0] ROW_HI     = IDX_W'(Y_TOP + SPR_H);
  localparam logic [IDX_W-1:0] SCR_X      = IDX_W'(SCREEN_W);
  localparam logic [IDX_W-1:0] SPAN_X     = IDX_W'(SCREEN_W + SPR_W);
  localparam logic [IDX_W-1:0] SPR_WX     = IDX_W'(SPR_W);
  localparam logic [IDX_W-1:0] SPR_NX     = IDX_W'(SPR_N);

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Number of set bits in a slot-active vector.
  function automatic logic [3:0] count_ones(input logic [N_OBS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < N_OBS; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  logic                 fresh_meta;
  logic                 fresh_sync;
  logic                 fresh_prev;
  logic                 tick;
  logic                 clear;
  logic                 step;

  logic [N_OBS-1:0]     act_q;
  logic [N_OBS-1:0]     act_n;
  logic [POS_W-1:0]     pos_q [N_OBS];
  logic [POS_W-1:0]     pos_n [N_OBS];
  logic [POS_W:0]       adv   [N_OBS];
  logic [15:0]          lfsr_q;
  logic [15:0]          lfsr_n;
  logic [GAP_W-1:0]     gap_q;
  logic [GAP_W-1:0]     gap_n;
  logic                 spawned;

  logic [IDX_W-1:0]     row_x;
  logic [IDX_W-1:0]     col_x;
  logic                 row_in;
  logic [IDX_W-1:0]     pos_x   [N_OBS];
  logic [IDX_W-1:0]     col_lo  [N_OBS];
  logic [IDX_W-1:0]     col_hi  [N_OBS];
  logic [IDX_W-1:0]     spr_idx [N_OBS];
  logic [N_OBS-1:0]     vis_p0;
  logic                 pix_p0;
  logic                 hit_p0;

  // Two-flop synchroniser for the frame strobe plus one delay for edge detect.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      fresh_meta <= 1'b0;
      fresh_sync <= 1'b0;
      fresh_prev <= 1'b0;
    end else begin
      fresh_meta <= fresh;
      fresh_sync <= fresh_meta;
      fresh_prev <= fresh_sync;
    end
  end

  // A frame tick is the synchronised falling edge of fresh.
  assign tick  = fresh_prev & ~fresh_sync;
  assign clear = START & ~game_status;
  assign step  = tick & game_status;

  // Position each slot would reach if it moved this tick.
  always_comb begin
    for (int s = 0; s < N_OBS; s++) begin
      adv[s] = {1'b0, pos_q[s]} + (POS_W+1)'(speed);
    end
  end

  // Next slot/gap/LFSR state: clear, or advance-retire-spawn on a running tick.
  always_comb begin
    act_n   = act_q;
    lfsr_n  = lfsr_q;
    gap_n   = gap_q;
    spawned = 1'b0;
    for (int s = 0; s < N_OBS; s++) pos_n[s] = pos_q[s];

    if (clear) begin
      act_n = '0;
      for (int s = 0; s < N_OBS; s++) pos_n[s] = '0;
      gap_n = GAP_RELOAD;
    end else if (step) begin
      // Advance and retire first, so a slot freed this tick can be reused.
      for (int s = 0; s < N_OBS; s++) begin
        if (act_q[s]) begin
          if (adv[s] >= RETIRE_AT) begin
            act_n[s] = 1'b0;
            pos_n[s] = '0;
          end else begin
            pos_n[s] = adv[s][POS_W-1:0];
          end
        end
      end

      lfsr_n = lfsr_step(lfsr_q);

      if (gap_q != '0) begin
        gap_n = gap_q - GAP_W'(1);
      end else begin
        // Lowest free slot wins; with no free slot the gap stays at zero
        // and the spawn is retried on the next tick.
        for (int s = 0; s < N_OBS; s++) begin
          if (!spawned && !act_n[s]) begin
            act_n[s] = 1'b1;
            pos_n[s] = '0;
            spawned  = 1'b1;
          end
        end
        if (spawned) gap_n = GAP_RELOAD + GAP_W'(lfsr_q[7:0] & GAP_MASK);
      end
    end
  end

  // Slot state register; active_cnt tracks the post-update slot set.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      act_q      <= '0;
      for (int s = 0; s < N_OBS; s++) pos_q[s] <= '0;
      lfsr_q     <= LFSR_SEED;
      gap_q      <= GAP_RELOAD;
      active_cnt <= '0;
    end else begin
      act_q      <= act_n;
      for (int s = 0; s < N_OBS; s++) pos_q[s] <= pos_n[s];
      lfsr_q     <= lfsr_n;
      gap_q      <= gap_n;
      active_cnt <= count_ones(act_n);
    end
  end

  // ---- stage p0: per-slot visibility and sprite lookup for the scan position
  always_comb begin
    row_x  = IDX_W'(row_addr);
    col_x  = IDX_W'(col_addr);
    row_in = (row_x >= ROW_LO) && (row_x < ROW_HI);
    vis_p0 = '0;
    for (int s = 0; s < N_OBS; s++) begin
      pos_x[s]   = IDX_W'(pos_q[s]);
      // A slot enters from the right edge: its left edge sits at SCREEN_W-pos
      // until pos passes SCREEN_W, after which it is clipped at column 0.
      col_lo[s]  = (pos_x[s] < SCR_X) ? (SCR_X - pos_x[s]) : '0;
      col_hi[s]  = SPAN_X - pos_x[s];
      spr_idx[s] = (col_x + pos_x[s] - SCR_X) + (row_x - ROW_LO) * SPR_WX;
      vis_p0[s]  = act_q[s] & row_in
                 & (col_x >= col_lo[s]) & (col_x < col_hi[s])
                 & (spr_idx[s] < SPR_NX)
                 & SPRITE[spr_idx[s][SPR_IW-1:0]];
    end
    pix_p0 = |vis_p0;
    hit_p0 = pix_p0 & dino_px;
  end

  // ---- stage p1: registered obstacle pixel
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) px <= 1'b0;
    else       px <= pix_p0;
  end

  // Sticky collision: armed only while running, cleared by reset or a start.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)                       collide <= 1'b0;
    else if (clear)                  collide <= 1'b0;
    else if (game_status && hit_p0)  collide <= 1'b1;
  end

endmodule

// File: tb/tb_obstacle_field.sv
// Testbench for obstacle_field: two instances (default 4-slot field and a
// 2-slot, gap-1 field) driven in lockstep and compared against a behavioural
// model of the obstacle field kept in plain integer arrays.
module tb_obstacle_field;

  localparam int SW    = 640;
  localparam int SPW   = 60;
  localparam int SPH   = 58;
  localparam int YT    = 344;
  localparam int SPAN  = SW + SPW;
  localparam int SPR_N = SPW * SPH;

  // 8-bit repeating pattern; with a 60-pixel row it shifts by 4 bits per row.
  localparam logic [SPR_N-1:0] SPR = {(SPR_N/8){8'b0110_1101}};

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       gs;
  logic       fresh;
  logic       dino;
  logic [3:0] speed;
  logic [8:0] row;
  logic [9:0] col;
  logic       px_a, coll_a, px_b, coll_b;
  logic [3:0] cnt_a, cnt_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  obstacle_field #(.SPRITE(SPR)) dut_a (
    .clk(clk), .RESET(rst), .START(start), .game_status(gs), .fresh(fresh),
    .speed(speed), .row_addr(row), .col_addr(col), .dino_px(dino),
    .px(px_a), .collide(coll_a), .active_cnt(cnt_a)
  );

  obstacle_field #(.N_OBS(2), .MIN_GAP(1), .GAP_MASK(8'h00), .SPRITE(SPR)) dut_b (
    .clk(clk), .RESET(rst), .START(start), .game_status(gs), .fresh(fresh),
    .speed(speed), .row_addr(row), .col_addr(col), .dino_px(dino),
    .px(px_b), .collide(coll_b), .active_cnt(cnt_b)
  );

  // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b)
  int          nobs  [2] = '{4, 2};
  int          mgap  [2] = '{40, 1};
  int          gmask [2] = '{63, 0};
  bit          m_act [2][8];
  int          m_pos [2][8];
  int          m_gap [2];
  logic [15:0] m_lfsr[2];
  bit          m_coll[2];

  function automatic void m_clear(int i);
    for (int s = 0; s < 8; s++) begin
      m_act[i][s] = 1'b0;
      m_pos[i][s] = 0;
    end
    m_gap[i]  = mgap[i];
    m_coll[i] = 1'b0;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_clear(i);
      m_lfsr[i] = 16'hACE1;
    end
  endfunction

  function automatic void m_tick(int i, int sp);
    logic [15:0] old;
    bit done;
    for (int s = 0; s < nobs[i]; s++) begin
      if (m_act[i][s]) begin
        if (m_pos[i][s] + sp >= SPAN) begin
          m_act[i][s] = 1'b0;
          m_pos[i][s] = 0;
        end else begin
          m_pos[i][s] = m_pos[i][s] + sp;
        end
      end
    end
    old = m_lfsr[i];
    m_lfsr[i] = {old[14:0], old[15] ^ old[13] ^ old[12] ^ old[10]};
    if (m_gap[i] > 0) begin
      m_gap[i] = m_gap[i] - 1;
    end else begin
      done = 1'b0;
      for (int s = 0; s < nobs[i]; s++) begin
        if (!done && !m_act[i][s]) begin
          m_act[i][s] = 1'b1;
          m_pos[i][s] = 0;
          m_gap[i]    = mgap[i] + (int'(old[7:0]) & gmask[i]);
          done        = 1'b1;
        end
      end
    end
  endfunction

  function automatic int m_count(int i);
    int n = 0;
    for (int s = 0; s < nobs[i]; s++) n += int'(m_act[i][s]);
    return n;
  endfunction

  function automatic bit m_pixel(int i, int r, int c);
    bit hit = 1'b0;
    int sc, sr;
    for (int s = 0; s < nobs[i]; s++) begin
      if (m_act[i][s]) begin
        sc = c + m_pos[i][s] - SW;
        sr = r - YT;
        if (sc >= 0 && sc < SPW && sr >= 0 && sr < SPH && SPR[sc + sr*SPW]) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // ---------------- stimulus helpers
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    fresh = 1'b1;
    cyc(3);
    fresh = 1'b0;
    cyc(4);
    if (gs) begin
      m_tick(0, int'(speed));
      m_tick(1, int'(speed));
    end
  endtask

  task automatic probe(int r, int c, bit d);
    row  = 9'(r);
    col  = 10'(c);
    dino = d;
    cyc(1);
    dino = 1'b0;
    if (gs && d) begin
      for (int i = 0; i < 2; i++) if (m_pixel(i, r, c)) m_coll[i] = 1'b1;
    end
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    m_reset();
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; gs = 1'b0; fresh = 1'b0; dino = 1'b0;
    speed = '0; row = '0; col = '0;
    #1;
    vectors++; if (px_a !== 1'b0) begin errors++; $display("FAIL reset_px_a: got %b, expected 0", px_a); end
    vectors++; if (coll_a !== 1'b0) begin errors++; $display("FAIL reset_coll_a: got %b, expected 0", coll_a); end
    vectors++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_cnt_a: got %0d, expected 0", cnt_a); end
    vectors++; if (cnt_b !== 4'd0) begin errors++; $display("FAIL reset_cnt_b: got %0d, expected 0", cnt_b); end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    m_reset();
  endtask

  task automatic test_spawn();
    gs = 1'b1;
    speed = 4'd4;
    for (int t = 1; t <= 42; t++) begin
      do_tick();
      vectors++; if (cnt_a !== 4'(m_count(0))) begin errors++; $display("FAIL spawn_cnt_a tick %0d: got %0d, expected %0d", t, cnt_a, m_count(0)); end
      vectors++; if (cnt_b !== 4'(m_count(1))) begin errors++; $display("FAIL spawn_cnt_b tick %0d: got %0d, expected %0d", t, cnt_b, m_count(1)); end
    end
    for (int r = YT - 1; r <= YT + SPH; r++) begin
      for (int c = 628; c < SW; c++) begin
        probe(r, c, 1'b0);
        vectors++; if (px_a !== m_pixel(0, r, c)) begin errors++; $display("FAIL spawn_px_a (%0d,%0d): got %b, expected %b", r, c, px_a, m_pixel(0, r, c)); end
        vectors++; if (px_b !== m_pixel(1, r, c)) begin errors++; $display("FAIL spawn_px_b (%0d,%0d): got %b, expected %b", r, c, px_b, m_pixel(1, r, c)); end
      end
    end
  endtask

  task automatic test_freeze();
    int pr[40];
    int pc[40];
    gs = 1'b0;
    for (int k = 0; k < 40; k++) begin
      pr[k] = $urandom_range(YT + SPH + 1, YT - 2);
      pc[k] = $urandom_range(639, 560);
    end
    repeat (10) do_tick();
    vectors++; if (cnt_a !== 4'(m_count(0))) begin errors++; $display("FAIL freeze_cnt_a: got %0d, expected %0d", cnt_a, m_count(0)); end
    vectors++; if (cnt_b !== 4'(m_count(1))) begin errors++; $display("FAIL freeze_cnt_b: got %0d, expected %0d", cnt_b, m_count(1)); end
    for (int k = 0; k < 40; k++) begin
      probe(pr[k], pc[k], 1'b0);
      vectors++; if (px_a !== m_pixel(0, pr[k], pc[k])) begin errors++; $display("FAIL freeze_px_a (%0d,%0d): got %b, expected %b", pr[k], pc[k], px_a, m_pixel(0, pr[k], pc[k])); end
      vectors++; if (px_b !== m_pixel(1, pr[k], pc[k])) begin errors++; $display("FAIL freeze_px_b (%0d,%0d): got %b, expected %b", pr[k], pc[k], px_b, m_pixel(1, pr[k], pc[k])); end
    end
    // START while running must not clear the field.
    gs = 1'b1;
    start = 1'b1;
    cyc(2);
    start = 1'b0;
    vectors++; if (cnt_a !== 4'(m_count(0))) begin errors++; $display("FAIL start_running_cnt_a: got %0d, expected %0d", cnt_a, m_count(0)); end
    do_tick();
    vectors++; if (cnt_b !== 4'(m_count(1))) begin errors++; $display("FAIL freeze_resume_cnt_b: got %0d, expected %0d", cnt_b, m_count(1)); end
  endtask

  task automatic test_collide();
    int n;
    hard_reset();
    gs = 1'b1;
    speed = 4'd4;
    n = 0;
    while (!m_pixel(0, 370, 620) && n < 120) begin
      do_tick();
      n++;
    end
    vectors++; if (n >= 120) begin errors++; $display("FAIL collide_setup: got %0d ticks, expected obstacle over (370,620) within 120", n); end
    gs = 1'b0;
    probe(370, 620, 1'b1);
    vectors++; if (coll_a !== m_coll[0]) begin errors++; $display("FAIL collide_frozen_a: got %b, expected %b", coll_a, m_coll[0]); end
    gs = 1'b1;
    probe(370, 620, 1'b1);
    vectors++; if (px_a !== m_pixel(0, 370, 620)) begin errors++; $display("FAIL collide_px_a: got %b, expected %b", px_a, m_pixel(0, 370, 620)); end
    vectors++; if (coll_a !== m_coll[0]) begin errors++; $display("FAIL collide_hit_a: got %b, expected %b", coll_a, m_coll[0]); end
    vectors++; if (coll_b !== m_coll[1]) begin errors++; $display("FAIL collide_hit_b: got %b, expected %b", coll_b, m_coll[1]); end
    speed = 4'd15;
    n = 0;
    while (m_act[0][0] && n < 60) begin
      do_tick();
      n++;
      vectors++; if (coll_a !== m_coll[0]) begin errors++; $display("FAIL collide_sticky_a tick %0d: got %b, expected %b", n, coll_a, m_coll[0]); end
      vectors++; if (cnt_a !== 4'(m_count(0))) begin errors++; $display("FAIL collide_cnt_a tick %0d: got %0d, expected %0d", n, cnt_a, m_count(0)); end
    end
    vectors++; if (n >= 60) begin errors++; $display("FAIL collide_leave: got %0d ticks, expected slot retirement within 60", n); end
    gs = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    m_clear(0);
    m_clear(1);
    vectors++; if (coll_a !== m_coll[0]) begin errors++; $display("FAIL start_clear_coll_a: got %b, expected %b", coll_a, m_coll[0]); end
    vectors++; if (coll_b !== m_coll[1]) begin errors++; $display("FAIL start_clear_coll_b: got %b, expected %b", coll_b, m_coll[1]); end
    vectors++; if (cnt_a !== 4'(m_count(0))) begin errors++; $display("FAIL start_clear_cnt_a: got %0d, expected %0d", cnt_a, m_count(0)); end
    vectors++; if (cnt_b !== 4'(m_count(1))) begin errors++; $display("FAIL start_clear_cnt_b: got %0d, expected %0d", cnt_b, m_count(1)); end
  endtask

  task automatic test_retire();
    int r, c;
    hard_reset();
    gs = 1'b1;
    speed = 4'd4;
    repeat (41) do_tick();
    speed = 4'd15;
    for (int t = 1; t <= 50; t++) begin
      do_tick();
      vectors++; if (cnt_a !== 4'(m_count(0))) begin errors++; $display("FAIL retire_cnt_a tick %0d: got %0d, expected %0d", t, cnt_a, m_count(0)); end
      vectors++; if (cnt_b !== 4'(m_count(1))) begin errors++; $display("FAIL retire_cnt_b tick %0d: got %0d, expected %0d", t, cnt_b, m_count(1)); end
      repeat (3) begin
        r = $urandom_range(YT + SPH - 1, YT);
        c = $urandom_range(639, 0);
        probe(r, c, 1'b0);
        vectors++; if (px_a !== m_pixel(0, r, c)) begin errors++; $display("FAIL retire_px_a (%0d,%0d): got %b, expected %b", r, c, px_a, m_pixel(0, r, c)); end
        vectors++; if (px_b !== m_pixel(1, r, c)) begin errors++; $display("FAIL retire_px_b (%0d,%0d): got %b, expected %b", r, c, px_b, m_pixel(1, r, c)); end
      end
    end
  endtask

  task automatic test_fill();
    hard_reset();
    gs = 1'b1;
    speed = 4'd1;
    for (int t = 1; t <= 710; t++) begin
      do_tick();
      vectors++; if (cnt_b !== 4'(m_count(1))) begin errors++; $display("FAIL fill_cnt_b tick %0d: got %0d, expected %0d", t, cnt_b, m_count(1)); end
      vectors++; if (cnt_a !== 4'(m_count(0))) begin errors++; $display("FAIL fill_cnt_a tick %0d: got %0d, expected %0d", t, cnt_a, m_count(0)); end
      if (t % 100 == 0 || t >= 698) begin
        for (int c = 0; c < 4; c++) begin
          probe(YT, c, 1'b0);
          vectors++; if (px_b !== m_pixel(1, YT, c)) begin errors++; $display("FAIL fill_px_b tick %0d col %0d: got %b, expected %b", t, c, px_b, m_pixel(1, YT, c)); end
        end
      end
    end
  endtask

  task automatic test_random();
    int r, c;
    bit d;
    hard_reset();
    for (int t = 1; t <= 300; t++) begin
      speed = 4'($urandom_range(15, 0));
      gs = ($urandom_range(19, 0) != 0);
      if ($urandom_range(24, 0) == 0) begin
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        if (!gs) begin
          m_clear(0);
          m_clear(1);
        end
      end
      do_tick();
      vectors++; if (cnt_a !== 4'(m_count(0))) begin errors++; $display("FAIL rand_cnt_a iter %0d: got %0d, expected %0d", t, cnt_a, m_count(0)); end
      vectors++; if (cnt_b !== 4'(m_count(1))) begin errors++; $display("FAIL rand_cnt_b iter %0d: got %0d, expected %0d", t, cnt_b, m_count(1)); end
      repeat (4) begin
        r = $urandom_range(410, 330);
        c = $urandom_range(639, 0);
        d = ($urandom_range(7, 0) == 0);
        probe(r, c, d);
        vectors++; if (px_a !== m_pixel(0, r, c)) begin errors++; $display("FAIL rand_px_a (%0d,%0d): got %b, expected %b", r, c, px_a, m_pixel(0, r, c)); end
        vectors++; if (px_b !== m_pixel(1, r, c)) begin errors++; $display("FAIL rand_px_b (%0d,%0d): got %b, expected %b", r, c, px_b, m_pixel(1, r, c)); end
        vectors++; if (coll_a !== m_coll[0]) begin errors++; $display("FAIL rand_coll_a iter %0d: got %b, expected %b", t, coll_a, m_coll[0]); end
        vectors++; if (coll_b !== m_coll[1]) begin errors++; $display("FAIL rand_coll_b iter %0d: got %b, expected %b", t, coll_b, m_coll[1]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int fr, fc;
    bit found;
    gs = 1'b1;
    speed = 4'd4;
    if (m_count(0) == 0) repeat (45) do_tick();
    fr = 370;
    fc = 620;
    found = 1'b0;
    for (int r = YT; r < YT + SPH; r++) begin
      for (int c = 0; c < SW; c++) begin
        if (!found && m_pixel(0, r, c)) begin
          fr = r;
          fc = c;
          found = 1'b1;
        end
      end
    end
    probe(fr, fc, 1'b1);
    vectors++; if (px_a !== m_pixel(0, fr, fc)) begin errors++; $display("FAIL midreset_pre_px_a (%0d,%0d): got %b, expected %b", fr, fc, px_a, m_pixel(0, fr, fc)); end
    vectors++; if (coll_a !== m_coll[0]) begin errors++; $display("FAIL midreset_pre_coll_a: got %b, expected %b", coll_a, m_coll[0]); end
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (px_a !== 1'b0) begin errors++; $display("FAIL midreset_px_a: got %b, expected 0", px_a); end
    vectors++; if (coll_a !== 1'b0) begin errors++; $display("FAIL midreset_coll_a: got %b, expected 0", coll_a); end
    vectors++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL midreset_cnt_a: got %0d, expected 0", cnt_a); end
    vectors++; if (px_b !== 1'b0) begin errors++; $display("FAIL midreset_px_b: got %b, expected 0", px_b); end
    vectors++; if (cnt_b !== 4'd0) begin errors++; $display("FAIL midreset_cnt_b: got %0d, expected 0", cnt_b); end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    m_reset();
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_freeze();
    test_collide();
    test_retire();
    test_fill();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded 2000000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
